arm_instr_encoder: RTL

//  Streaming ARM instruction assembler: packs field requests (class, subtype, cond, opcode, regs, operands) into 32-bit words.
//  Its class/subtype codes and bit layouts are the ones the instruction-classification decoder consumes.

---
 rtl/arm_instr_pkg.sv | 55 +++++
 rtl/arm_instr_pack.sv | 79 +++++++
 rtl/arm_instr_encoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arm_instr_pkg.sv
// ============================================================================
// Module   : arm_instr_pkg
// Purpose  : Class/subtype codes, instruction bit positions and FSM state type
//            shared by the ARM instruction encoder and its field packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_instr_pkg;

  // Instruction class codes (match the classification decoder)
  localparam logic [1:0] CLS_ILL = 2'b00;
  localparam logic [1:0] CLS_DP  = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  // Data-processing operand-2 subtypes
  localparam logic [2:0] SUB_IMM = 3'b001;
  localparam logic [2:0] SUB_RSI = 3'b010;
  localparam logic [2:0] SUB_RSR = 3'b011;

  // Word layout
  localparam int COND_MSB     = 31;
  localparam int COND_LSB     = 28;
  localparam int CLS_MSB      = 27;
  localparam int CLS_LSB      = 26;
  localparam int I_BIT        = 25;
  localparam int OPC_MSB      = 24;
  localparam int OPC_LSB      = 21;
  localparam int S_BIT        = 20;
  localparam int RN_LSB       = 16;
  localparam int RD_LSB       = 12;
  localparam int OP2_MSB      = 11;
  localparam int BR_MSB       = 27;
  localparam int BR_LSB       = 25;
  localparam int LINK_BIT     = 24;
  localparam int SH_REG_BIT   = 4;
  localparam int RSR_ZERO_BIT = 7;

  localparam logic [1:0] CLS_FIELD_DP  = 2'b00;
  localparam logic [1:0] CLS_FIELD_MEM = 2'b01;
  localparam logic [2:0] BR_FIELD      = 3'b101;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_t;

  function automatic logic dp_sub_legal(input logic [2:0] sub);
    return (sub == SUB_IMM) || (sub == SUB_RSI) || (sub == SUB_RSR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arm_instr_pack.sv
// ============================================================================
// Module   : arm_instr_pack
// Purpose  : Combinational field-to-word packer with illegal-request flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_instr_pack
  import arm_instr_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [2:0]  sub,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] op2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);

  logic [11:0] w_op2;

  // Register-shift forms pin the bits that distinguish them from each other
  always_comb begin
    w_op2 = op2;
    if (sub == SUB_RSI) begin
      w_op2[SH_REG_BIT] = 1'b0;
    end else if (sub == SUB_RSR) begin
      w_op2[RSR_ZERO_BIT] = 1'b0;
      w_op2[SH_REG_BIT]   = 1'b1;
    end
  end

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (cls)
      CLS_DP: begin
        if (dp_sub_legal(sub)) begin
          word[COND_MSB:COND_LSB] = cond;
          word[CLS_MSB:CLS_LSB]   = CLS_FIELD_DP;
          word[I_BIT]             = (sub == SUB_IMM);
          word[OPC_MSB:OPC_LSB]   = opcode;
          word[S_BIT]             = s;
          word[RN_LSB +: 4]       = rn;
          word[RD_LSB +: 4]       = rd;
          word[OP2_MSB:0]         = w_op2;
        end else begin
          illegal = 1'b1;
        end
      end
      CLS_MEM: begin
        word[COND_MSB:COND_LSB] = cond;
        word[CLS_MSB:CLS_LSB]   = CLS_FIELD_MEM;
        word[I_BIT]             = 1'b0;
        word[OPC_MSB:OPC_LSB]   = opcode;
        word[S_BIT]             = s;
        word[RN_LSB +: 4]       = rn;
        word[RD_LSB +: 4]       = rd;
        word[OP2_MSB:0]         = op2;
      end
      CLS_BR: begin
        word[COND_MSB:COND_LSB] = cond;
        word[BR_MSB:BR_LSB]     = BR_FIELD;
        word[LINK_BIT]          = s;
        word[23:0]              = imm24;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/arm_instr_encoder.sv
// ============================================================================
// Module   : arm_instr_encoder
// Purpose  : Streaming ARM instruction assembler with valid/ready handshakes
//            and a single-entry full-throughput output register.
//            Optional per-class counters when ENC_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_instr_encoder
  import arm_instr_pkg::*;
#(
  parameter int SEQ_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cls,
  input  logic [2:0]        in_sub,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_op2,
  input  logic [23:0]       in_imm24,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic              out_err,
`ifdef ENC_STATS_EN
  output logic [STAT_W-1:0] stat_dp,
  output logic [STAT_W-1:0] stat_mem,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_err,
`endif
  output logic [SEQ_W-1:0]  out_seq
);

  enc_state_t       r_state;
  logic             r_valid;
  logic [31:0]      r_word;
  logic             r_err;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_next_seq;

  logic [31:0]      w_word;
  logic             w_illegal;
  logic             w_accept;

  arm_instr_pack u_pack (
    .cls     (in_cls),
    .sub     (in_sub),
    .cond    (in_cond),
    .opcode  (in_opcode),
    .s       (in_s),
    .rn      (in_rn),
    .rd      (in_rd),
    .op2     (in_op2),
    .imm24   (in_imm24),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // A consumer draining this cycle frees the slot for a same-cycle refill
  assign in_ready = (r_state == EMPTY) | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_valid    <= 1'b0;
      r_word     <= 32'h0;
      r_err      <= 1'b0;
      r_seq      <= '0;
      r_next_seq <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= FULL;
            r_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready && !w_accept) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
      if (w_accept) begin
        r_word     <= w_word;
        r_err      <= w_illegal;
        r_seq      <= r_next_seq;
        r_next_seq <= r_next_seq + SEQ_W'(1);
      end
    end
  end

  assign out_valid = r_valid;
  assign out_word  = r_word;
  assign out_err   = r_err;
  assign out_seq   = r_seq;

`ifdef ENC_STATS_EN
  logic [STAT_W-1:0] r_stat_dp;
  logic [STAT_W-1:0] r_stat_mem;
  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_err;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

  // Illegal requests count only as errors, never against their class
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_dp  <= '0;
      r_stat_mem <= '0;
      r_stat_br  <= '0;
      r_stat_err <= '0;
    end else if (w_accept) begin
      if (w_illegal) begin
        r_stat_err <= sat_inc(r_stat_err);
      end else begin
        case (in_cls)
          CLS_DP:  r_stat_dp  <= sat_inc(r_stat_dp);
          CLS_MEM: r_stat_mem <= sat_inc(r_stat_mem);
          CLS_BR:  r_stat_br  <= sat_inc(r_stat_br);
          default: r_stat_err <= r_stat_err;
        endcase
      end
    end
  end

  assign stat_dp  = r_stat_dp;
  assign stat_mem = r_stat_mem;
  assign stat_br  = r_stat_br;
  assign stat_err = r_stat_err;
`endif

endmodule

`default_nettype wire
